// File: rtl/rcas_pkg.sv
// rcas_pkg: shared encodings for the rcas accumulator sequencer.
//   op_t    : command opcodes carried on cmd_op (LOAD/ADD/SUB/CLR).
//   state_t : sequencer states (IDLE accepts, EXEC computes, RESP presents).
package rcas_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/rcas_addsub_w.sv
// rcas_addsub_w: combinational W-bit ripple-carry adder/subtractor.
//   a, b  : operands
//   con   : 0 = a + b, 1 = a - b (b inverted, carry-in of 1)
//   s     : W-bit sum
//   cout  : carry-out; for subtraction 1 means no borrow
module rcas_addsub_w #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         con,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] bx;
    logic [W:0]   sum;

    always_comb begin
        bx  = b ^ {W{con}};
        sum = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, con};
    end

    assign s    = sum[W-1:0];
    assign cout = sum[W];

endmodule

// File: rtl/rcas_acc_seq.sv
// rcas_acc_seq: command-sequenced accumulator around rcas_addsub_w.
//   clk, rst             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_op, cmd_data     : opcode (LOAD/ADD/SUB/CLR) and operand
//   res_valid/res_ready  : result handshake (valid only in RESP)
//   acc, cout, ovf, zero : registered accumulator and flags
// Optional macro RCAS_ACC_SAT_EN: unsigned saturation of ADD/SUB results;
// cout/ovf still report the raw datapath values.
module rcas_acc_seq
    import rcas_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] acc,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    state_t       state;
    state_t       state_nxt;
    op_t          op_reg;
    logic [W-1:0] data_reg;

    logic         con;
    logic [W-1:0] bx;
    logic [W-1:0] s;
    logic         c;

    logic [W-1:0] acc_nxt;
    logic         cout_nxt;
    logic         ovf_nxt;

    // Datapath: accumulator is always operand A.
    assign con = (op_reg == OP_SUB);
    assign bx  = data_reg ^ {W{con}};

    rcas_addsub_w #(.W(W)) u_addsub (
        .a    (acc),
        .b    (data_reg),
        .con  (con),
        .s    (s),
        .cout (c)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (cmd_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        res_valid = (state == ST_RESP);
    end

    // Command capture on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg   <= OP_LOAD;
            data_reg <= '0;
        end else if (state == ST_IDLE && cmd_valid) begin
            op_reg   <= op_t'(cmd_op);
            data_reg <= cmd_data;
        end
    end

    // Result selection for the EXEC cycle
    always_comb begin
        acc_nxt  = acc;
        cout_nxt = 1'b0;
        ovf_nxt  = 1'b0;
        unique case (op_reg)
            OP_LOAD: acc_nxt = data_reg;
            OP_CLR:  acc_nxt = '0;
            OP_ADD, OP_SUB: begin
                cout_nxt = c;
                ovf_nxt  = (acc[W-1] == bx[W-1]) && (s[W-1] != acc[W-1]);
`ifdef RCAS_ACC_SAT_EN
                if (op_reg == OP_ADD) begin
                    acc_nxt = c ? '1 : s;
                end else begin
                    acc_nxt = c ? s : '0;
                end
`else
                acc_nxt = s;
`endif
            end
            default: acc_nxt = acc;
        endcase
    end

    // Accumulator and flag registers, updated only in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b1;
        end else if (state == ST_EXEC) begin
            acc  <= acc_nxt;
            cout <= cout_nxt;
            ovf  <= ovf_nxt;
            zero <= (acc_nxt == '0);
        end
    end

endmodule

// File: tb/tb_rcas_acc_seq.sv
module tb_rcas_acc_seq;

    localparam int W   = 3;
    localparam int MOD = 1 << W;

    localparam logic [1:0] C_LOAD = 2'b00;
    localparam logic [1:0] C_ADD  = 2'b01;
    localparam logic [1:0] C_SUB  = 2'b10;
    localparam logic [1:0] C_CLR  = 2'b11;

`ifdef RCAS_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] acc;
    logic         cout;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    rcas_acc_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .acc       (acc),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned/signed values
    typedef struct {
        int acc;
        int cout;
        int ovf;
    } r_t;

    function automatic int sgn(input int v);
        return (v >= MOD / 2) ? v - MOD : v;
    endfunction

    function automatic r_t ref_op(input int a, input int op, input int b);
        r_t r;
        int sv;
        r.acc = 0; r.cout = 0; r.ovf = 0;
        case (op)
            0: r.acc = b;
            1: begin
                r.cout = (a + b >= MOD) ? 1 : 0;
                r.acc  = (a + b) % MOD;
                sv     = sgn(a) + sgn(b);
                r.ovf  = (sv < -MOD / 2 || sv >= MOD / 2) ? 1 : 0;
                if (SAT && r.cout == 1) r.acc = MOD - 1;
            end
            2: begin
                r.cout = (a >= b) ? 1 : 0;
                r.acc  = (a - b + MOD) % MOD;
                sv     = sgn(a) - sgn(b);
                r.ovf  = (sv < -MOD / 2 || sv >= MOD / 2) ? 1 : 0;
                if (SAT && r.cout == 0) r.acc = 0;
            end
            default: r.acc = 0;
        endcase
        return r;
    endfunction

    // Transaction-level expectations
    bit model_on = 1'b0;
    bit busy     = 1'b0;
    bit pend     = 1'b0;
    bit resp_now = 1'b0;
    int cyc      = 0;
    int due      = 0;
    int m_acc = 0, m_cout = 0, m_ovf = 0, m_zero = 1;
    r_t p;

    always @(negedge clk) begin
        cyc++;
        if (model_on) begin
            if (pend && cyc == due) begin
                m_acc    = p.acc;
                m_cout   = p.cout;
                m_ovf    = p.ovf;
                m_zero   = (p.acc == 0) ? 1 : 0;
                pend     = 1'b0;
                resp_now = 1'b1;
            end
            chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
            chk("res_valid", 32'(res_valid), 32'(resp_now));
            chk("acc",  32'(acc),  32'(m_acc));
            chk("cout", 32'(cout), 32'(m_cout));
            chk("ovf",  32'(ovf),  32'(m_ovf));
            chk("zero", 32'(zero), 32'(m_zero));
        end
        if (rst === 1'b1) begin
            model_on = 1'b1;
            m_acc = 0; m_cout = 0; m_ovf = 0; m_zero = 1;
            busy = 1'b0; pend = 1'b0; resp_now = 1'b0;
        end else if (model_on) begin
            if (resp_now && res_ready) begin
                resp_now = 1'b0;
                busy     = 1'b0;
            end else if (!busy && cmd_valid) begin
                p    = ref_op(m_acc, int'(cmd_op), int'(cmd_data));
                pend = 1'b1;
                due  = cyc + 2;
                busy = 1'b1;
            end
        end
    end

    task automatic send(input logic [1:0] op, input int d);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = W'(d);
        do begin
            @(negedge clk);
            n++;
        end while (!(cmd_ready === 1'b1 && rst === 1'b0) && n < 50);
        if (cmd_ready !== 1'b1) chk("accept_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_resp(input int delay);
        int n = 0;
        res_ready = 1'b0;
        while (res_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (res_valid !== 1'b1) chk("resp_timeout", 32'(0), 32'(1));
        repeat (delay + 1) @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input int d, input int delay);
        send(op, d);
        get_resp(delay);
    endtask

    task automatic lit(input string name, input int a, input int c, input int v, input int z);
        @(negedge clk);
        chk({name, "_acc"},  32'(acc),  32'(a));
        chk({name, "_cout"}, 32'(cout), 32'(c));
        chk({name, "_ovf"},  32'(ovf),  32'(v));
        chk({name, "_zero"}, 32'(zero), 32'(z));
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog expired at t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        r_t r;
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; cmd_op = 2'b00; cmd_data = '0;

        // Pin the model against hand-computed values (raw, non-saturating cases)
        r = ref_op(3, 1, 1);
        chk("model_add_ovf_acc", 32'(r.acc), 32'(4));
        chk("model_add_ovf_flag", 32'(r.ovf), 32'(1));
        r = ref_op(0, 2, 4);
        chk("model_sub_neg4_ovf", 32'(r.ovf), 32'(1));
        chk("model_sub_neg4_cout", 32'(r.cout), 32'(0));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        lit("rst", 0, 0, 0, 1);

        // Wrap / carry
        do_cmd(C_LOAD, 5, 0);
        do_cmd(C_ADD, 3, 0);
        if (SAT) lit("add_wrap", 7, 1, 0, 0); else lit("add_wrap", 0, 1, 0, 1);

        // Signed overflow
        do_cmd(C_LOAD, 3, 0);
        do_cmd(C_ADD, 1, 1);
        lit("add_ovf", 4, 0, 1, 0);

        // Borrow
        do_cmd(C_LOAD, 2, 0);
        do_cmd(C_SUB, 3, 0);
        if (SAT) lit("sub_borrow", 0, 0, 0, 1); else lit("sub_borrow", 7, 0, 0, 0);
        do_cmd(C_LOAD, 3, 0);
        do_cmd(C_SUB, 3, 2);
        lit("sub_equal", 0, 1, 0, 1);

        // Backpressure: command held during RESP must not be accepted
        send(C_LOAD, 6);
        while (res_valid !== 1'b1) @(negedge clk);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = C_ADD; cmd_data = 3'd1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_acc", 32'(acc), 32'(6));
            chk("bp_cmd_ready", 32'(cmd_ready), 32'(0));
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_after_release", 32'(cmd_ready), 32'(1));
        @(posedge clk); #1 cmd_valid = 1'b0;
        get_resp(0);
        lit("bp_add", 7, 0, 0, 0);

        // Clear
        do_cmd(C_LOAD, 4, 0);
        do_cmd(C_CLR, 0, 0);
        lit("clr", 0, 0, 0, 1);

        // Reset during EXEC
        do_cmd(C_LOAD, 5, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = C_ADD; cmd_data = 3'd2;
        @(negedge clk);
        chk("rst_exec_accept", 32'(cmd_ready), 32'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_exec_res_valid", 32'(res_valid), 32'(0));
        chk("rst_exec_cmd_ready", 32'(cmd_ready), 32'(1));
        lit("rst_exec", 0, 0, 0, 1);

        // Randomized traffic
        repeat (200) begin
            logic [1:0] op;
            int d;
            op = 2'($urandom_range(0, 3));
            d  = int'($urandom_range(0, MOD - 1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_cmd(op, d, int'($urandom_range(0, 3)));
        end
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
